// File: rtl/fifo_rdstream.sv
// fifo_rdstream
// Read-side drain engine for a FIFO controller with external synchronous
// memory. Issues fiford while the controller reports notempty and there is
// room for the word, captures rddata RDLAT cycles later into a small local
// queue, and presents that queue as a valid/ready stream.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset, clears all state
//   notempty  FIFO controller holds at least one word
//   fiford    read request to FIFO controller (accepted whenever high)
//   rddata    memory read data, valid RDLAT cycles after a fiford cycle
//   flush     synchronous discard of queue and in-flight reads
//   o_valid   output word available (registered-state only)
//   o_ready   consumer accepts the word
//   o_data    head of the local queue
//   o_cnt     words delivered, wraps modulo 2^16
//   busy      queue non-empty or reads in flight
module fifo_rdstream #(
  parameter int DATABIT = 32,
  parameter int RDLAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               notempty,
  output logic               fiford,
  input  logic [DATABIT-1:0] rddata,
  input  logic               flush,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [DATABIT-1:0] o_data,
  output logic [15:0]        o_cnt,
  output logic               busy
);

  // Two spare entries beyond the read latency let the stream sustain one
  // word per cycle without o_ready feeding combinationally into fiford.
  localparam int DEPTH = RDLAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  logic [RDLAT-1:0]   rdvld_reg;
  logic [RDLAT-1:0]   rdvld_next;
  logic [RDLAT:0]     rdvld_ext;
  logic [CW-1:0]      occ_reg;
  logic [CW-1:0]      occ_next;
  logic [CW-1:0]      infl;
  logic [CW:0]        slots_used;
  logic [PW-1:0]      wrptr_reg;
  logic [PW-1:0]      wrptr_next;
  logic [PW-1:0]      rdptr_reg;
  logic [PW-1:0]      rdptr_next;
  logic [DATABIT-1:0] queue_reg [DEPTH];
  logic [15:0]        cnt_reg;
  logic               push;
  logic               pop;

  // Number of reads issued whose data has not landed yet.
  always_comb begin
    infl = '0;
    for (int i = 0; i < RDLAT; i++) begin
      infl = infl + CW'(rdvld_reg[i]);
    end
  end

  // Every in-flight read has a reserved queue slot, so the queue can never
  // overflow regardless of what the consumer does.
  assign slots_used = {1'b0, occ_reg} + {1'b0, infl};
  assign fiford     = notempty & ~flush & ~rst & (slots_used < (CW+1)'(DEPTH));

  assign o_valid = (occ_reg != '0);
  assign o_data  = queue_reg[rdptr_reg];
  assign o_cnt   = cnt_reg;
  assign busy    = (occ_reg != '0) | (rdvld_reg != '0);

  // Data returning during a flush cycle is dropped, and no pop is taken.
  assign push = rdvld_reg[RDLAT-1] & ~flush;
  assign pop  = o_valid & o_ready & ~flush;

  // Latency pipeline: stage 0 holds this cycle's fiford.
  assign rdvld_ext  = {rdvld_reg, fiford};
  assign rdvld_next = flush ? '0 : rdvld_ext[RDLAT-1:0];

  always_comb begin
    wrptr_next = wrptr_reg;
    rdptr_next = rdptr_reg;
    occ_next   = occ_reg;
    if (flush) begin
      wrptr_next = '0;
      rdptr_next = '0;
      occ_next   = '0;
    end else begin
      if (push) begin
        wrptr_next = (wrptr_reg == PW'(DEPTH - 1)) ? '0 : wrptr_reg + 1'b1;
      end
      if (pop) begin
        rdptr_next = (rdptr_reg == PW'(DEPTH - 1)) ? '0 : rdptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_next = occ_reg + 1'b1;
        2'b01:   occ_next = occ_reg - 1'b1;
        default: occ_next = occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdvld_reg <= '0;
      occ_reg   <= '0;
      wrptr_reg <= '0;
      rdptr_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      rdvld_reg <= rdvld_next;
      occ_reg   <= occ_next;
      wrptr_reg <= wrptr_next;
      rdptr_reg <= rdptr_next;
      if (pop) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  // Queue storage is reset so o_data reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        queue_reg[i] <= '0;
      end
    end else if (push) begin
      queue_reg[wrptr_reg] <= rddata;
    end
  end

endmodule
